// File: rtl/cheshire_io_mux.sv
// Run-time pad multiplexer with glitch-safe function switching.
// Pad inputs are synchronised; pad outputs and enables are registered.
module cheshire_io_mux #(
   parameter int unsigned         NumPads     = 32,
   parameter int unsigned         NumFuncs    = 4,
   parameter int unsigned         GuardCycles = 4,
   parameter int unsigned         SyncStages  = 2,
   parameter logic [NumFuncs-1:0] FuncIdleIn  = '0,
   localparam int unsigned FuncW = (NumFuncs > 1) ? $clog2(NumFuncs) : 1,
   localparam int unsigned PadW  = (NumPads > 1) ? $clog2(NumPads) : 1
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               cfg_valid_i,
   output logic                               cfg_ready_o,
   input  logic [PadW-1:0]                    cfg_pad_i,
   input  logic [FuncW-1:0]                   cfg_func_i,
   output logic                               cfg_err_o,
   output logic                               busy_o,
   output logic [NumPads-1:0][FuncW-1:0]      sel_o,
   input  logic [NumPads-1:0]                 pad_i,
   output logic [NumPads-1:0]                 pad_o,
   output logic [NumPads-1:0]                 pad_oe_o,
   input  logic [NumFuncs-1:0][NumPads-1:0]   func_o_i,
   input  logic [NumFuncs-1:0][NumPads-1:0]   func_oe_i,
   output logic [NumFuncs-1:0][NumPads-1:0]   func_in_o
);

   typedef enum logic {IDLE, GUARD} state_e;

   state_e                              state_q, state_d;
   logic [7:0]                          cnt_q, cnt_d;
   logic [PadW-1:0]                     tgt_pad_q, tgt_pad_d;
   logic [FuncW-1:0]                    tgt_func_q, tgt_func_d;
   logic [NumPads-1:0][FuncW-1:0]       sel_q, sel_d;
   logic                                err_q, err_d;
   logic [NumPads-1:0]                  pad_q, pad_d;
   logic [NumPads-1:0]                  oe_q, oe_d;
   logic [SyncStages-1:0][NumPads-1:0]  sync_q, sync_d;

   logic [NumPads-1:0]                  mask;
   logic [NumPads-1:0]                  pad_sync;
   logic [FuncW-1:0]                    cur_sel;
   logic                                req_bad;

   assign pad_sync = sync_q[SyncStages-1];

   always_comb begin
      cur_sel = '0;
      for (int p = 0; p < NumPads; p++) begin
         if (cfg_pad_i == PadW'(p)) cur_sel = sel_q[p];
      end
   end

   assign req_bad = (32'(cfg_pad_i) >= NumPads) ||
                    (32'(cfg_func_i) >= NumFuncs);

   always_comb begin
      for (int p = 0; p < NumPads; p++) begin
         mask[p] = (state_q == GUARD) && (tgt_pad_q == PadW'(p));
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_pad_d  = tgt_pad_q;
      tgt_func_d = tgt_func_q;
      sel_d      = sel_q;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_valid_i) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else if (cfg_func_i != cur_sel) begin
                  state_d    = GUARD;
                  cnt_d      = 8'(GuardCycles - 1);
                  tgt_pad_d  = cfg_pad_i;
                  tgt_func_d = cfg_func_i;
               end
            end
         end
         GUARD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               for (int p = 0; p < NumPads; p++) begin
                  if (tgt_pad_q == PadW'(p)) sel_d[p] = tgt_func_q;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      endcase
   end

   // The guarded pad is parked low and tristated until the new selection lands.
   always_comb begin
      for (int p = 0; p < NumPads; p++) begin
         pad_d[p] = !mask[p] && func_o_i[sel_q[p]][p];
         oe_d[p]  = !mask[p] && func_oe_i[sel_q[p]][p];
      end
   end

   always_comb begin
      sync_d[0] = pad_i;
      for (int s = 1; s < SyncStages; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_comb begin
      for (int f = 0; f < NumFuncs; f++) begin
         for (int p = 0; p < NumPads; p++) begin
            if (!mask[p] && (sel_q[p] == FuncW'(f))) begin
               func_in_o[f][p] = pad_sync[p];
            end else begin
               func_in_o[f][p] = FuncIdleIn[f];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tgt_pad_q  <= '0;
         tgt_func_q <= '0;
         sel_q      <= '0;
         err_q      <= 1'b0;
         pad_q      <= '0;
         oe_q       <= '0;
         sync_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_pad_q  <= tgt_pad_d;
         tgt_func_q <= tgt_func_d;
         sel_q      <= sel_d;
         err_q      <= err_d;
         pad_q      <= pad_d;
         oe_q       <= oe_d;
         sync_q     <= sync_d;
      end
   end

   assign cfg_ready_o = (state_q == IDLE) && !rst_i;
   assign busy_o      = (state_q == GUARD) && !rst_i;
   assign cfg_err_o   = err_q;
   assign sel_o       = sel_q;
   assign pad_o       = pad_q;
   assign pad_oe_o    = oe_q;

endmodule
